ibuf_stream_seq: RTL and testbench
==================================

Name: ibuf_stream_seq

Overview:
- Sequencer that owns the single address/data/write port of one single-port ibuf RAM bank (ASIZE/DSIZE, 1-cycle registered read).
- It fills the bank from an upstream valid/ready stream, then drains it in address order to a downstream valid/ready stream with full backpressure.
- Sits between the DDR read path (axim) and the compute pipeline.

Parameters:
- ASIZE, 10, RAM address width; DEPTH = 2^ASIZE words.
- DSIZE, 32, data word width.

Ports:
- I_clk  in  1  single clock.
- I_rst  in  1  reset, asynchronous, active-high.
- I_start  in  1  one-cycle request to begin a fill/drain frame; sampled in IDLE only.
- I_len  in  ASIZE+1  frame length in words, 0..DEPTH; latched on accepted I_start.
- I_wdata  in  DSIZE  upstream data.
- I_wvalid  in  1  upstream valid.
- O_wready  out  1  upstream ready.
- O_rdata  out  DSIZE  downstream data.
- O_rvalid  out  1  downstream valid.
- I_rready  in  1  downstream ready.
- O_ram_addr  out  ASIZE  RAM address.
- O_ram_data  out  DSIZE  RAM write data.
- O_ram_wr  out  1  RAM write enable.
- I_ram_q  in  DSIZE  RAM read data, valid 1 cycle after the address.
- O_busy  out  1  high in FILL/DRAIN.
- O_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async assert, sync-released flops): state=IDLE; counters, skid entries and every output = 0.
- FSM:
  - IDLE: on I_start, latch len = min(I_len, DEPTH). If len=0, pulse O_done next cycle and stay IDLE; else go to FILL. I_start outside IDLE is ignored.
  - FILL: O_wready=1 (combinational on state). Each beat with I_wvalid&O_wready sets O_ram_wr=1, O_ram_addr=wr_cnt, O_ram_data=I_wdata, and increments wr_cnt. The beat with wr_cnt==len-1 moves to DRAIN; O_wready=0 from the next cycle.
  - DRAIN: issue read at address rd_cnt, 0..len-1; data returns on I_ram_q one cycle later into a 2-entry output skid FIFO.
    - A read is issued in cycle t iff rd_cnt<len and (fifo_cnt + inflight - pop_t) < 2, where pop_t = O_rvalid&I_rready. A bubble-free stream is therefore sustained at 1 word/cycle under constant ready.
    - O_rvalid = fifo non-empty. O_rdata = FIFO head, which is stable while O_rvalid&!I_rready (AXIS rule).
    - When the len-th word pops: O_done=1 for exactly one cycle (the next cycle), state→IDLE, and counters clear.
- O_ram_wr is never asserted in DRAIN. O_ram_addr is 0 in IDLE. I_ram_q is ignored except in the cycle after an issued read.
- O_busy = (state != IDLE).
- Wrap-around: none. Addresses never exceed len-1; len=DEPTH uses addresses 0..DEPTH-1 exactly.
- Simultaneous push+pop on the skid FIFO in the same cycle keeps its count unchanged.
- An async reset mid-frame aborts the frame with no O_done. RAM contents are left as-is (not cleared).

Decomposition:
- Shared package (cnna_pkg) holds the state encoding localparams ST_IDLE=2'd0, ST_FILL=2'd1, ST_DRAIN=2'd2, and SKID_DEPTH=2.
- One natural sub-module: ibuf_skid2, a 2-entry valid/ready FIFO with push/data/pop and a count output, instantiated at the read-data return.

Test Plan:
- len=4, upstream writes 0xA0..0xA3 back-to-back with I_rready=1 → writes at addr 0..3; O_rdata sequence 0xA0..0xA3 on 4 consecutive cycles; O_done pulses once; O_busy returns to 0.
- len=8 with I_rready toggling 1,0,0,1,… → all 8 words delivered in order, none dropped or duplicated; O_rdata held stable on every stalled cycle; at most 2 reads in flight+buffered.
- len=0 → no RAM access, O_done pulses 1 cycle after I_start, O_busy stays 0.
- I_len=DEPTH+5 with ASIZE=4 → clamps to 16; addresses 0..15 each written once, then read once; exactly 16 output beats.
- I_start pulsed during FILL and DRAIN → ignored, frame length unchanged; I_wvalid gaps during FILL → wr_cnt advances only on handshakes.
- I_rst asserted mid-DRAIN (after 3 of 8 words) → all outputs 0 immediately, no O_done; a new frame of len=2 afterwards completes correctly.

Source files
------------

// File: rtl/cnna_pkg.sv
// cnna_pkg: shared state encoding and skid sizing for the ibuf stream sequencer
package cnna_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int SKID_DEPTH = 2;
    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FILL  = ST_FILL,
        S_DRAIN = ST_DRAIN
    } state_t;
endpackage

// File: rtl/ibuf_skid2.sv
// ibuf_skid2: 2-entry FIFO catching RAM read data so the head holds while downstream stalls
module ibuf_skid2
    import cnna_pkg::*;
#(
    parameter int DSIZE = 32
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_push,
    input  logic [DSIZE-1:0] I_data,
    input  logic             I_pop,
    output logic [DSIZE-1:0] O_head,
    output logic             O_valid,
    output logic [1:0]       O_cnt
);
    localparam logic [1:0] FULL = 2'(SKID_DEPTH);
    logic [DSIZE-1:0] e0, e1;
    logic [1:0] cnt;
    logic pop_ok, push_ok;
    assign pop_ok  = I_pop && cnt != 2'd0;
    assign push_ok = I_push && (cnt != FULL || pop_ok);
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= '0;
        end else begin
            if (pop_ok && cnt == 2'd2)
                e0 <= e1;
            else if (push_ok && (cnt == 2'd0 || (cnt == 2'd1 && pop_ok)))
                e0 <= I_data;
            if (push_ok && ((cnt == 2'd1 && !pop_ok) || (cnt == 2'd2 && pop_ok)))
                e1 <= I_data;
            cnt <= cnt + 2'(push_ok) - 2'(pop_ok);
        end
    end
    assign O_head  = e0;
    assign O_valid = cnt != 2'd0;
    assign O_cnt   = cnt;
endmodule

// File: rtl/ibuf_stream_seq.sv
// ibuf_stream_seq: fills one single-port ibuf bank from an upstream stream, then drains it in order
// downstream with backpressure, using a 2-entry skid to absorb the 1-cycle RAM read latency.
module ibuf_stream_seq
    import cnna_pkg::*;
#(
    parameter int ASIZE = 10,
    parameter int DSIZE = 32
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_start,
    input  logic [ASIZE:0]   I_len,
    input  logic [DSIZE-1:0] I_wdata,
    input  logic             I_wvalid,
    output logic             O_wready,
    output logic [DSIZE-1:0] O_rdata,
    output logic             O_rvalid,
    input  logic             I_rready,
    output logic [ASIZE-1:0] O_ram_addr,
    output logic [DSIZE-1:0] O_ram_data,
    output logic             O_ram_wr,
    input  logic [DSIZE-1:0] I_ram_q,
    output logic             O_busy,
    output logic             O_done
);
    localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(2**ASIZE);
    state_t state, state_n;
    logic [ASIZE:0] len, wr_cnt, rd_cnt, pop_cnt, start_len;
    logic inflight, done_q, wbeat, pop, issue, last_wr, last_pop, accept;
    logic [1:0] fifo_cnt;
    logic [2:0] occ;
    assign start_len = (I_len > DEPTH) ? DEPTH : I_len;
    assign accept    = state == S_IDLE && I_start;
    assign wbeat     = state == S_FILL && I_wvalid;
    assign pop       = O_rvalid && I_rready;
    // occupancy the skid will see once in-flight data lands, net of this cycle's pop
    assign occ       = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = state == S_DRAIN && rd_cnt < len && occ < 3'd2;
    assign last_wr   = wbeat && wr_cnt == len - 1'b1;
    assign last_pop  = pop && pop_cnt == len - 1'b1;
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n    = state;
        O_wready   = state == S_FILL;
        O_busy     = state != S_IDLE;
        O_ram_wr   = wbeat;
        O_ram_data = wbeat ? I_wdata : '0;
        O_ram_addr = (state == S_FILL) ? wr_cnt[ASIZE-1:0] : issue ? rd_cnt[ASIZE-1:0] : '0;
        if (accept && start_len != '0)
            state_n = S_FILL;
        if (last_wr)
            state_n = S_DRAIN;
        if (last_pop)
            state_n = S_IDLE;
    end
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            len      <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            pop_cnt  <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= last_pop || (accept && start_len == '0);
            if (accept)
                len <= start_len;
            if (wbeat)
                wr_cnt <= wr_cnt + 1'b1;
            if (issue)
                rd_cnt <= rd_cnt + 1'b1;
            if (pop)
                pop_cnt <= pop_cnt + 1'b1;
            if (last_pop) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                pop_cnt <= '0;
            end
        end
    end
    ibuf_skid2 #(.DSIZE(DSIZE)) u_skid (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_push (inflight),
        .I_data (I_ram_q),
        .I_pop  (pop),
        .O_head (O_rdata),
        .O_valid(O_rvalid),
        .O_cnt  (fifo_cnt)
    );
    assign O_done = done_q;
endmodule

// File: tb/tb_ibuf_stream_seq.sv
// tb_ibuf_stream_seq: directed frames with a queue scoreboard checked by independent monitors
module tb_ibuf_stream_seq;
    localparam int AS = 4;
    localparam int DS = 32;
    logic I_clk = 0, I_rst = 1, I_start = 0, I_wvalid = 0, I_rready = 1, O_wready, O_rvalid;
    logic O_ram_wr, O_busy, O_done;
    logic [AS:0] I_len = '0;
    logic [DS-1:0] I_wdata = '0, O_rdata, O_ram_data, I_ram_q = '0;
    logic [AS-1:0] O_ram_addr;
    logic [DS-1:0] mem [16];
    logic [AS-1:0] wa_q[$];
    logic [DS-1:0] wd_q[$], ex_q[$];
    int pop_cyc[$];
    int errors = 0, checks = 0, cyc = 0, beats = 0, done_cnt = 0, rr_mode = 0, ph = 0;
    logic held = 0;
    logic [DS-1:0] hold_v = '0;

    ibuf_stream_seq #(.ASIZE(AS), .DSIZE(DS)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_len(I_len),
        .I_wdata(I_wdata), .I_wvalid(I_wvalid), .O_wready(O_wready),
        .O_rdata(O_rdata), .O_rvalid(O_rvalid), .I_rready(I_rready),
        .O_ram_addr(O_ram_addr), .O_ram_data(O_ram_data), .O_ram_wr(O_ram_wr),
        .I_ram_q(I_ram_q), .O_busy(O_busy), .O_done(O_done)
    );

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc++;
    always @(posedge I_clk) begin
        if (O_ram_wr) mem[O_ram_addr] <= O_ram_data;
        I_ram_q <= mem[O_ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    // downstream ready: constant 1, or the 1,0,0 repeating stall pattern
    initial forever begin
        @(posedge I_clk);
        #1;
        I_rready = (rr_mode == 0) ? 1'b1 : (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
    end

    // monitor: RAM writes, output beats, stall stability, done pulses
    always @(negedge I_clk) begin
        if (I_rst) begin
            held = 0;
        end else begin
            if (O_ram_wr) begin
                if (wa_q.size() == 0) fail_now("unexpected_ram_wr");
                else begin
                    chk("wr_addr", 64'(O_ram_addr), 64'(wa_q.pop_front()));
                    chk("wr_data", 64'(O_ram_data), 64'(wd_q.pop_front()));
                end
            end
            if (held && O_rvalid) chk("stall_stable", 64'(O_rdata), 64'(hold_v));
            held = O_rvalid && !I_rready;
            hold_v = O_rdata;
            if (O_rvalid && I_rready) begin
                beats++;
                pop_cyc.push_back(cyc);
                if (ex_q.size() == 0) fail_now("unexpected_beat");
                else chk("rdata", 64'(O_rdata), 64'(ex_q.pop_front()));
            end
            if (O_done) done_cnt++;
        end
    end

    task automatic start(input int len);
        I_start = 1;
        I_len = (AS+1)'(len);
        tick();
        I_start = 0;
    endtask

    task automatic send(input int n, input logic [DS-1:0] base, input int gap, input int start_at);
        logic hs;
        for (int i = 0; i < n; i++) begin
            wa_q.push_back(i[AS-1:0]);
            wd_q.push_back(base + DS'(i));
            ex_q.push_back(base + DS'(i));
            I_wvalid = 1;
            I_wdata = base + DS'(i);
            if (i == start_at) begin
                I_start = 1;
                I_len = 5'd2;
            end
            for (int k = 0; ; k++) begin
                hs = O_wready;
                tick();
                I_start = 0;
                if (hs) break;
                if (k > 50) begin
                    fail_now("wready_timeout");
                    break;
                end
            end
            I_wvalid = 0;
            I_wdata = 32'hDEAD_BEEF;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge I_clk);
            #1;
            if (O_done) break;
            n++;
        end
        if (n >= 300) fail_now("done_timeout");
        else chk("busy_at_done", 64'(O_busy), 64'd0);
        tick();
    endtask

    initial begin
        int d0, b0;
        repeat (2) @(negedge I_clk);
        chk("rst_outputs", {O_wready, O_rvalid, O_rdata, O_ram_addr, O_ram_data, O_ram_wr, O_busy, O_done}, '0);
        tick();
        I_rst = 0;
        tick();

        // len=4, back-to-back, constant ready
        d0 = done_cnt; b0 = beats; pop_cyc.delete();
        start(4);
        chk("busy_fill", 64'(O_busy), 64'd1);
        send(4, 32'hA0, 0, -1);
        chk("wready_drain", 64'(O_wready), 64'd0);
        wait_done();
        tick();
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_beats", 64'(beats - b0), 64'd4);
        chk("t1_burst", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // len=8, ready 1,0,0 pattern
        d0 = done_cnt; b0 = beats; rr_mode = 1;
        start(8);
        send(8, 32'h1000_0C00, 0, -1);
        wait_done();
        tick();
        chk("t2_done", 64'(done_cnt - d0), 64'd1);
        chk("t2_beats", 64'(beats - b0), 64'd8);
        chk("t2_queue", 64'(ex_q.size()), 64'd0);
        rr_mode = 0;

        // len=0
        d0 = done_cnt;
        I_start = 1;
        I_len = '0;
        @(negedge I_clk);
        chk("t3_busy0", 64'(O_busy), 64'd0);
        tick();
        I_start = 0;
        @(negedge I_clk);
        chk("t3_done", 64'(O_done), 64'd1);
        chk("t3_busy1", 64'(O_busy), 64'd0);
        @(negedge I_clk);
        chk("t3_done_pulse", 64'(O_done), 64'd0);
        tick();
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // I_len beyond depth clamps to 16
        d0 = done_cnt; b0 = beats;
        start(21);
        send(16, 32'h5500, 0, -1);
        chk("t4_wready", 64'(O_wready), 64'd0);
        wait_done();
        tick();
        chk("t4_done", 64'(done_cnt - d0), 64'd1);
        chk("t4_beats", 64'(beats - b0), 64'd16);

        // start pulses in FILL and DRAIN ignored; gaps on upstream valid
        d0 = done_cnt; b0 = beats; rr_mode = 1;
        start(5);
        send(5, 32'h7700, 2, 2);
        I_start = 1;
        I_len = 5'd3;
        tick();
        I_start = 0;
        wait_done();
        tick();
        chk("t5_done", 64'(done_cnt - d0), 64'd1);
        chk("t5_beats", 64'(beats - b0), 64'd5);
        chk("t5_idle", 64'(O_busy), 64'd0);
        rr_mode = 0;

        // async reset mid-drain
        d0 = done_cnt; b0 = beats;
        start(8);
        send(8, 32'hD0, 0, -1);
        for (int k = 0; beats < b0 + 3 && k < 100; k++) tick();
        chk("t6_partial", 64'(beats - b0 < 8), 64'd1);
        I_rst = 1;
        #1;
        chk("t6_rst_outputs", {O_wready, O_rvalid, O_rdata, O_ram_addr, O_ram_data, O_ram_wr, O_busy, O_done}, '0);
        ex_q.delete();
        repeat (2) tick();
        I_rst = 0;
        repeat (3) tick();
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        d0 = done_cnt; b0 = beats;
        start(2);
        send(2, 32'hB0, 0, -1);
        wait_done();
        tick();
        chk("t6_done", 64'(done_cnt - d0), 64'd1);
        chk("t6_beats", 64'(beats - b0), 64'd2);

        chk("end_wq", 64'(wa_q.size()), 64'd0);
        chk("end_rq", 64'(ex_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
